// File: rtl/gshare_br_predictor.sv
// Branch predictor for FE: global-history (or bimodal) indexed PHT of 2-bit counters,
// direct-mapped tagged BTB, and a saturating mispredict counter. Lookup is combinational.
module gshare_br_predictor #(
    parameter int         DBITS        = 32,
    parameter int         HIST_BITS    = 8,
    parameter int         BTB_IDX_BITS = 4,
    parameter int         INDEX_MODE   = 0,
    parameter logic [1:0] CNT_INIT     = 2'b01
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DBITS-1:0]     pred_pc,
    output logic                 pred_hit,
    output logic                 pred_taken,
    output logic [DBITS-1:0]     pred_next_pc,
    output logic [HIST_BITS-1:0] pred_pht_idx,
    input  logic                 upd_valid,
    input  logic [DBITS-1:0]     upd_pc,
    input  logic                 upd_is_cond,
    input  logic                 upd_taken,
    input  logic [DBITS-1:0]     upd_target,
    input  logic [HIST_BITS-1:0] upd_pht_idx,
    input  logic                 upd_mispredict,
    output logic [HIST_BITS-1:0] bhr_out,
    output logic [31:0]          mispred_cnt
);

    localparam int PHT_N = 1 << HIST_BITS;
    localparam int BTB_N = 1 << BTB_IDX_BITS;
    localparam int TAG_W = DBITS - BTB_IDX_BITS - 2;

    logic [1:0]              pht_q     [PHT_N];
    logic [1:0]              pht_d     [PHT_N];
    logic                    btb_vld_q [BTB_N];
    logic                    btb_vld_d [BTB_N];
    logic [TAG_W-1:0]        btb_tag_q [BTB_N];
    logic [TAG_W-1:0]        btb_tag_d [BTB_N];
    logic [DBITS-1:0]        btb_tgt_q [BTB_N];
    logic [DBITS-1:0]        btb_tgt_d [BTB_N];
    logic                    btb_cond_q[BTB_N];
    logic                    btb_cond_d[BTB_N];
    logic [HIST_BITS-1:0]    bhr_q, bhr_d;
    logic [31:0]             mispred_cnt_q, mispred_cnt_d;

    logic [HIST_BITS-1:0]    lk_pidx;
    logic [BTB_IDX_BITS-1:0] lk_idx;
    logic [TAG_W-1:0]        lk_tag;
    logic [BTB_IDX_BITS-1:0] up_idx;
    logic [TAG_W-1:0]        up_tag;
    logic                    unused_pc_bits;

    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic up);
        if (up)
            ctr_next = (c == 2'b11) ? c : c + 2'd1;
        else
            ctr_next = (c == 2'b00) ? c : c - 2'd1;
    endfunction

    function automatic logic [31:0] cnt_sat_inc(input logic [31:0] c);
        cnt_sat_inc = (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    // Word-aligned PCs: bits [1:0] never contribute to any index or tag.
    assign unused_pc_bits = ^{pred_pc[1:0], upd_pc[1:0]};

    assign lk_pidx = pred_pc[HIST_BITS+1:2] ^ ((INDEX_MODE == 0) ? bhr_q : '0);
    assign lk_idx  = pred_pc[BTB_IDX_BITS+1:2];
    assign lk_tag  = pred_pc[DBITS-1:BTB_IDX_BITS+2];
    assign up_idx  = upd_pc[BTB_IDX_BITS+1:2];
    assign up_tag  = upd_pc[DBITS-1:BTB_IDX_BITS+2];

    // Lookup reads only registered state, so a same-cycle update is never bypassed.
    always_comb begin
        pred_hit     = btb_vld_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
        pred_taken   = pred_hit && (!btb_cond_q[lk_idx] || pht_q[lk_pidx][1]);
        pred_next_pc = pred_taken ? btb_tgt_q[lk_idx] : pred_pc + DBITS'(4);
        pred_pht_idx = lk_pidx;
    end

    assign bhr_out     = bhr_q;
    assign mispred_cnt = mispred_cnt_q;

    always_comb begin
        pht_d         = pht_q;
        btb_vld_d     = btb_vld_q;
        btb_tag_d     = btb_tag_q;
        btb_tgt_d     = btb_tgt_q;
        btb_cond_d    = btb_cond_q;
        bhr_d         = bhr_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_valid) begin
            if (upd_is_cond) begin
                pht_d[upd_pht_idx] = ctr_next(pht_q[upd_pht_idx], upd_taken);
                bhr_d              = {bhr_q[HIST_BITS-2:0], upd_taken};
            end
            // Not-taken outcomes never allocate and never invalidate a BTB entry.
            if (upd_taken) begin
                btb_vld_d[up_idx]  = 1'b1;
                btb_tag_d[up_idx]  = up_tag;
                btb_tgt_d[up_idx]  = upd_target;
                btb_cond_d[up_idx] = upd_is_cond;
            end
            if (upd_mispredict)
                mispred_cnt_d = cnt_sat_inc(mispred_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bhr_q         <= '0;
            mispred_cnt_q <= '0;
            for (int i = 0; i < PHT_N; i++) pht_q[i] <= CNT_INIT;
            for (int i = 0; i < BTB_N; i++) btb_vld_q[i] <= 1'b0;
        end else begin
            bhr_q         <= bhr_d;
            mispred_cnt_q <= mispred_cnt_d;
            for (int i = 0; i < PHT_N; i++) pht_q[i] <= pht_d[i];
            for (int i = 0; i < BTB_N; i++) btb_vld_q[i] <= btb_vld_d[i];
        end
    end

    // BTB payload is qualified by its valid bit, so it carries no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BTB_N; i++) begin
            btb_tag_q[i]  <= btb_tag_d[i];
            btb_tgt_q[i]  <= btb_tgt_d[i];
            btb_cond_q[i] <= btb_cond_d[i];
        end
    end

endmodule

// File: tb/tb_gshare_br_predictor.sv
// Scoreboard bench: gshare instance plus a bimodal instance sharing all inputs.
module tb_gshare_br_predictor;

    localparam int DBITS = 32;
    localparam int HB    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   pred_pc;
    logic          upd_valid, upd_is_cond, upd_taken, upd_mispredict;
    logic [31:0]   upd_pc, upd_target;
    logic [HB-1:0] upd_pht_idx;

    logic          a_hit, a_taken, b_hit, b_taken;
    logic [31:0]   a_next, b_next, a_cnt, b_cnt;
    logic [HB-1:0] a_idx, b_idx, a_bhr, b_bhr;

    always #5 clk = ~clk;

    gshare_br_predictor #(.DBITS(DBITS), .HIST_BITS(HB), .BTB_IDX_BITS(4), .INDEX_MODE(0)) dut_a (
        .clk(clk), .reset(reset), .pred_pc(pred_pc),
        .pred_hit(a_hit), .pred_taken(a_taken), .pred_next_pc(a_next), .pred_pht_idx(a_idx),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_cond(upd_is_cond), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pht_idx(upd_pht_idx), .upd_mispredict(upd_mispredict),
        .bhr_out(a_bhr), .mispred_cnt(a_cnt)
    );

    gshare_br_predictor #(.DBITS(DBITS), .HIST_BITS(HB), .BTB_IDX_BITS(4), .INDEX_MODE(1)) dut_b (
        .clk(clk), .reset(reset), .pred_pc(pred_pc),
        .pred_hit(b_hit), .pred_taken(b_taken), .pred_next_pc(b_next), .pred_pht_idx(b_idx),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_cond(upd_is_cond), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pht_idx(upd_pht_idx), .upd_mispredict(upd_mispredict),
        .bhr_out(b_bhr), .mispred_cnt(b_cnt)
    );

    typedef enum {K_LOOK_A, K_LOOK_B, K_BHR, K_CNT, K_PHT} kind_t;
    typedef struct {
        kind_t       kind;
        string       name;
        logic        hit;
        logic        taken;
        logic [31:0] next;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic chk_req = 1'b0;
    exp_t e;

    // Monitor: drains every expectation queued for the current sample point.
    always @(negedge clk) begin
        if (chk_req) begin
            while (q.size() > 0) begin
                e = q.pop_front();
                n_tests++;
                case (e.kind)
                    K_LOOK_A, K_LOOK_B: begin
                        logic          h, t;
                        logic [31:0]   n;
                        logic [HB-1:0] ix;
                        h  = (e.kind == K_LOOK_A) ? a_hit   : b_hit;
                        t  = (e.kind == K_LOOK_A) ? a_taken : b_taken;
                        n  = (e.kind == K_LOOK_A) ? a_next  : b_next;
                        ix = (e.kind == K_LOOK_A) ? a_idx   : b_idx;
                        if (h !== e.hit || t !== e.taken || n !== e.next || ix !== e.val[HB-1:0]) begin
                            n_fail++;
                            $display("FAIL %s: got hit=%0b taken=%0b next=%h idx=%h, expected hit=%0b taken=%0b next=%h idx=%h",
                                     e.name, h, t, n, ix, e.hit, e.taken, e.next, e.val[HB-1:0]);
                        end
                    end
                    K_BHR: if (a_bhr !== e.val[HB-1:0]) begin
                        n_fail++;
                        $display("FAIL %s: got bhr=%h, expected %h", e.name, a_bhr, e.val[HB-1:0]);
                    end
                    K_CNT: if (a_cnt !== e.val) begin
                        n_fail++;
                        $display("FAIL %s: got mispred_cnt=%0d, expected %0d", e.name, a_cnt, e.val);
                    end
                    K_PHT: if (dut_a.pht_q[e.next[HB-1:0]] !== e.val[1:0]) begin
                        n_fail++;
                        $display("FAIL %s: got pht[%h]=%b, expected %b", e.name, e.next[HB-1:0],
                                 dut_a.pht_q[e.next[HB-1:0]], e.val[1:0]);
                    end
                    default: ;
                endcase
            end
        end
    end

    function automatic void push(kind_t k, string nm, logic h, logic t, logic [31:0] n, logic [31:0] v);
        exp_t x;
        x.kind = k; x.name = nm; x.hit = h; x.taken = t; x.next = n; x.val = v;
        q.push_back(x);
    endfunction

    function automatic void look_a(string nm, logic [31:0] pc, logic h, logic t, logic [31:0] n, logic [31:0] ix);
        pred_pc = pc;
        push(K_LOOK_A, nm, h, t, n, ix);
    endfunction

    function automatic void exp_bhr(string nm, logic [31:0] v); push(K_BHR, nm, 0, 0, 0, v); endfunction
    function automatic void exp_cnt(string nm, logic [31:0] v); push(K_CNT, nm, 0, 0, 0, v); endfunction
    function automatic void exp_pht(string nm, logic [31:0] ix, logic [31:0] v); push(K_PHT, nm, 0, 0, ix, v); endfunction

    task automatic sample();
        chk_req = 1'b1;
        @(negedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic cond, input logic tk,
                           input logic [31:0] tgt, input logic [HB-1:0] ix, input logic mis);
        upd_valid = 1'b1; upd_pc = pc; upd_is_cond = cond; upd_taken = tk;
        upd_target = tgt; upd_pht_idx = ix; upd_mispredict = mis;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; pred_pc = 32'h0;
        upd_valid = 0; upd_pc = 0; upd_is_cond = 0; upd_taken = 0;
        upd_target = 0; upd_pht_idx = 0; upd_mispredict = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        look_a("rst_look", 32'h100, 0, 0, 32'h104, 32'h40);
        exp_bhr("rst_bhr", 0); exp_cnt("rst_cnt", 0); exp_pht("rst_pht40", 32'h40, 2'b01);
        sample();

        set_upd(32'h100, 1, 1, 32'h200, 8'h40, 0); tick();
        exp_pht("cond_pht40", 32'h40, 2'b10); exp_bhr("cond_bhr", 32'h01);
        look_a("gshare_look", 32'h100, 1, 0, 32'h104, 32'h41);
        push(K_LOOK_B, "bimodal_look", 1, 1, 32'h200, 32'h40);
        sample();

        set_upd(32'h100, 1, 1, 32'h200, 8'h40, 1); upd_valid = 1'b0; tick();
        exp_bhr("novld_bhr", 32'h01); exp_cnt("novld_cnt", 0); exp_pht("novld_pht", 32'h40, 2'b10);
        sample();

        set_upd(32'h300, 0, 1, 32'h080, 8'h00, 0); tick();
        exp_bhr("jal_bhr", 32'h01); exp_pht("jal_pht00", 32'h00, 2'b01);
        look_a("jal_look", 32'h300, 1, 1, 32'h080, 32'hC1);
        sample();
        look_a("jal_evict", 32'h100, 0, 0, 32'h104, 32'h41);
        sample();

        repeat (3) begin set_upd(32'h40, 1, 1, 32'h600, 8'h10, 0); tick(); end
        exp_pht("sat_up3", 32'h10, 2'b11);
        sample();
        set_upd(32'h40, 1, 1, 32'h600, 8'h10, 0); tick();
        exp_pht("sat_up4", 32'h10, 2'b11); exp_bhr("sat_up_bhr", 32'h1F);
        sample();

        set_upd(32'h40, 1, 0, 32'h600, 8'h10, 0); tick();
        set_upd(32'h40, 1, 0, 32'h600, 8'h10, 0);
        pred_pc = 32'h40;
        push(K_LOOK_B, "same_cycle", 1, 1, 32'h600, 32'h10);
        exp_pht("same_cycle_pht", 32'h10, 2'b10);
        sample();
        tick();
        push(K_LOOK_B, "after_dec", 1, 0, 32'h44, 32'h10);
        look_a("after_dec_a", 32'h40, 1, 0, 32'h44, 32'h6C);
        sample();
        repeat (2) begin set_upd(32'h40, 1, 0, 32'h600, 8'h10, 0); tick(); end
        exp_pht("sat_dn4", 32'h10, 2'b00); exp_bhr("sat_dn_bhr", 32'hF0);
        sample();

        set_upd(32'h100, 0, 1, 32'h200, 8'h00, 0); tick();
        look_a("cfl_own", 32'h100, 1, 1, 32'h200, 32'hB0);
        sample();
        look_a("cfl_miss", 32'h140, 0, 0, 32'h144, 32'hA0);
        sample();
        set_upd(32'h140, 0, 1, 32'h400, 8'h00, 0); tick();
        look_a("cfl_old", 32'h100, 0, 0, 32'h104, 32'hB0);
        sample();
        look_a("cfl_new", 32'h140, 1, 1, 32'h400, 32'hA0);
        sample();
        set_upd(32'h140, 1, 0, 32'h999, 8'h20, 0); tick();
        look_a("nt_keep", 32'h140, 1, 1, 32'h400, 32'hB0);
        exp_pht("nt_pht20", 32'h20, 2'b00);
        sample();

        repeat (3) begin set_upd(32'h140, 0, 0, 32'h0, 8'h00, 1); tick(); end
        set_upd(32'h140, 0, 0, 32'h0, 8'h00, 1); upd_valid = 1'b0; tick();
        exp_cnt("mis_cnt3", 3); exp_bhr("mis_bhr", 32'hE0);
        sample();

        @(posedge clk);
        #2 reset = 1'b1;
        exp_cnt("arst_cnt", 0); exp_bhr("arst_bhr", 0); exp_pht("arst_pht", 32'h10, 2'b01);
        look_a("arst_look", 32'h140, 0, 0, 32'h144, 32'h50);
        sample();
        reset = 1'b0;

        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gshare_br_predictor.md
Name: gshare_br_predictor

Overview:
- Parametrised successor to the fixed-size branch predictor/updater pair feeding FE.
- Combines a global-history-indexed PHT of 2-bit counters, a direct-mapped tagged BTB and a saturating mispredict counter.
- FE performs a zero-latency lookup each cycle. AGEX delivers one resolved branch/jump update per cycle, applied at the clock edge.
- Supports gshare or bimodal indexing.

Parameters:
- DBITS, 32, PC/target width.
- HIST_BITS, 8, BHR width; PHT has 2^HIST_BITS entries.
- BTB_IDX_BITS, 4, BTB has 2^BTB_IDX_BITS entries.
- INDEX_MODE, 0, 0 = gshare (PC index XOR BHR), 1 = bimodal (PC index only).
- CNT_INIT, 2'b01, PHT counter value after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- pred_pc  in  DBITS  PC being fetched.
- pred_hit  out  1  BTB valid and tag match for pred_pc.
- pred_taken  out  1  predicted taken.
- pred_next_pc  out  DBITS  predicted next fetch PC.
- pred_pht_idx  out  HIST_BITS  PHT index used for this lookup; travels down the pipe.
- upd_valid  in  1  resolved control-flow instruction this cycle.
- upd_pc  in  DBITS  PC of resolved instruction.
- upd_is_cond  in  1  1 = conditional branch, 0 = JAL/JALR.
- upd_taken  in  1  actual direction.
- upd_target  in  DBITS  actual target.
- upd_pht_idx  in  HIST_BITS  pred_pht_idx captured at fetch.
- upd_mispredict  in  1  AGEX detected a wrong next PC.
- bhr_out  out  HIST_BITS  current global history (debug).
- mispred_cnt  out  32  saturating mispredict count.

Behaviour:
- Indexing:
  - pidx = pred_pc[HIST_BITS+1:2], XORed with BHR when INDEX_MODE = 0.
  - BTB index = pc[BTB_IDX_BITS+1:2].
  - BTB tag = pc[DBITS-1:BTB_IDX_BITS+2].
  - BTB entry fields: valid, tag, target, is_cond.
- Lookup (purely combinational, same cycle):
  - pred_hit = valid & tag match.
  - pred_taken = pred_hit & (~is_cond | PHT[pidx][1]).
  - pred_next_pc = pred_taken ? BTB target : pred_pc+4 (modulo 2^DBITS).
  - pred_pht_idx = pidx, always driven, even on a miss.
- Update (posedge, only when upd_valid):
  - PHT, conditional only: PHT[upd_pht_idx] +1 if taken, -1 if not taken. Saturates at 2'b11 / 2'b00.
  - BHR, conditional only: BHR <= {BHR[HIST_BITS-2:0], upd_taken}. BHR is unchanged by jumps.
  - BTB, if upd_taken: write valid=1, tag, target, is_cond, replacing any conflicting entry.
  - BTB, if not taken: unchanged; no allocation and no invalidation.
  - mispred_cnt increments when upd_mispredict is set; holds at 32'hFFFF_FFFF.
- Simultaneous lookup and update to the same entry: the lookup sees pre-update contents; no bypass.
- Reset (asynchronous, effective immediately, including mid-update):
  - BHR = 0.
  - All PHT counters = CNT_INIT.
  - All BTB valid = 0.
  - mispred_cnt = 0.
  - Outputs immediately: pred_hit = 0, pred_taken = 0, pred_next_pc = pred_pc+4, bhr_out = 0.
- Inputs with upd_valid low are ignored. The block has no stall input; FE may repeat a lookup freely.

Test Plan (defaults: HIST_BITS=8, BTB_IDX_BITS=4):
- Post-reset lookup, pred_pc=0x100 -> pred_hit=0, pred_taken=0, pred_next_pc=0x104, pred_pht_idx=0x40.
- Update cond taken, pc=0x100, target=0x200, pht_idx=0x40. Then:
  - PHT[0x40]=2'b10, bhr_out=0x01.
  - Lookup 0x100 -> hit=1, pht_idx=0x41, PHT[0x41]=01 so taken=0, next=0x104.
  - Same sequence with INDEX_MODE=1 -> taken=1, next=0x200.
- Update JAL pc=0x300, target=0x080 -> bhr_out unchanged. Lookup 0x300 -> taken=1, next=0x080.
- Saturation on pht_idx=0x10:
  - 3 taken updates -> 2'b11; a 4th stays 2'b11.
  - Then 4 not-taken updates -> 2'b00.
  - Simultaneous same-cycle lookup shows the old value.
- Conflict on BTB index 0 (0x100 allocated to 0x200):
  - Lookup 0x140 -> hit=0.
  - Taken update 0x140 -> 0x400; then 0x100 misses and 0x140 hits with target 0x400.
- Issue 3 upd_mispredict pulses -> mispred_cnt=3. Assert reset asynchronously between edges -> mispred_cnt=0, bhr_out=0, pred_hit=0 before the next clock edge.
